// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM stage of the 32-bit integer pipeline. Sequences one data-memory
//   access per EX op using a req/ack handshake:
//   - generates byte lanes and lane-replicated store data
//   - aligns loads and applies sign/zero extension
//   - stalls the front of the pipe while an access is outstanding
//   - reports misaligned accesses and bus timeouts as one-cycle pulses that
//     coincide with wb_valid_o
//   Non-memory EX results pass through to WB one cycle later.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ex_valid_i            EX result valid this cycle
//   ex_addr_i             ALU result / effective address
//   ex_wdata_i            store data (rs2)
//   ex_read_i/ex_write_i  load / store op (both set: store)
//   ex_size_i             00 byte, 01 half, 1x word
//   ex_unsigned_i         zero-extend loads (LBU/LHU)
//   stall_o               hold EX and earlier stages
//   wb_valid_o            one-cycle WB payload strobe
//   wb_data_o             load result, ex_addr for non-memory ops, else 0
//   exc_misalign_o        misaligned access (with wb_valid_o)
//   exc_bus_o             ack timeout (with wb_valid_o)
//   mem_req_o ..          data-memory request bundle, stable while pending
//   mem_rdata_i, mem_ack_i  read data and transfer-complete from memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_valid_i,
   input  logic [XLEN-1:0]   ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   input  logic              ex_read_i,
   input  logic              ex_write_i,
   input  logic [1:0]        ex_size_i,
   input  logic              ex_unsigned_i,
   output logic              stall_o,
   output logic              wb_valid_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              exc_misalign_o,
   output logic              exc_bus_o,
   output logic              mem_req_o,
   output logic              mem_write_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic [XLEN-1:0]   mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int LANES = XLEN / 8;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Byte-lane enables for an access of the given size at the given lane offset.
   function automatic logic [LANES-1:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
      logic [LANES-1:0] be;
      case (size)
         2'b00:   be = LANES'(1) << lane;
         2'b01:   be = LANES'(3) << {lane[1], 1'b0};
         default: be = '1;
      endcase
      return be;
   endfunction

   // Replicate narrow store data across every lane so the memory picks it by be.
   function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] d);
      logic [XLEN-1:0] wd;
      case (size)
         2'b00:   wd = {(XLEN/8){d[7:0]}};
         2'b01:   wd = {(XLEN/16){d[15:0]}};
         default: wd = d;
      endcase
      return wd;
   endfunction

   // Shift the addressed lane down to bit 0 and extend to XLEN.
   function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size, input logic uns,
                                                   input logic [1:0] lane, input logic [XLEN-1:0] rdata);
      logic [XLEN-1:0] sh;
      logic            ext;
      logic [XLEN-1:0] res;
      sh = rdata >> {lane, 3'b000};
      case (size)
         2'b00: begin
            ext = uns ? 1'b0 : sh[7];
            res = {{(XLEN-8){ext}}, sh[7:0]};
         end
         2'b01: begin
            ext = uns ? 1'b0 : sh[15];
            res = {{(XLEN-16){ext}}, sh[15:0]};
         end
         default: begin
            ext = 1'b0;
            res = rdata;
         end
      endcase
      return res;
   endfunction

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_write_q, mem_write_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [LANES-1:0]  mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic [1:0]        op_size_q, op_size_d;
   logic              op_uns_q, op_uns_d;
   logic [1:0]        op_lane_q, op_lane_d;
   logic              wb_valid_q, wb_valid_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              exc_mis_q, exc_mis_d;
   logic              exc_bus_q, exc_bus_d;

   logic              is_mem_s;
   logic              misalign_s;
   logic              timeout_hit_s;

   assign is_mem_s      = ex_read_i | ex_write_i;
   // Size 2'b11 is a word, so size[1] covers both word encodings.
   assign misalign_s    = ((ex_size_i == 2'b01) & ex_addr_i[0]) |
                          (ex_size_i[1] & (ex_addr_i[1:0] != 2'b00));
   // cnt_q is 1 in the first BUSY cycle, so this fires on the TIMEOUT-th cycle of mem_req.
   assign timeout_hit_s = (state_q == ST_BUSY) && (cnt_q == CNT_W'(TIMEOUT));

   assign stall_o = ((state_q == ST_IDLE) & ex_valid_i & is_mem_s & ~misalign_s) |
                    ((state_q == ST_BUSY) & ~mem_ack_i & ~timeout_hit_s);

   // Next-state and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      op_size_d   = op_size_q;
      op_uns_d    = op_uns_q;
      op_lane_d   = op_lane_q;
      wb_valid_d  = 1'b0;
      wb_data_d   = '0;
      exc_mis_d   = 1'b0;
      exc_bus_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid_i) begin
               if (!is_mem_s) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = ex_addr_i;
               end else if (misalign_s) begin
                  wb_valid_d = 1'b1;
                  exc_mis_d  = 1'b1;
               end else begin
                  state_d     = ST_BUSY;
                  cnt_d       = CNT_W'(1);
                  mem_req_d   = 1'b1;
                  mem_write_d = ex_write_i;
                  mem_addr_d  = {ex_addr_i[XLEN-1:2], 2'b00};
                  mem_be_d    = byte_enable(ex_size_i, ex_addr_i[1:0]);
                  mem_wdata_d = store_data(ex_size_i, ex_wdata_i);
                  op_size_d   = ex_size_i;
                  op_uns_d    = ex_unsigned_i;
                  op_lane_d   = ex_addr_i[1:0];
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // An ack arriving on the timeout cycle still completes normally.
            if (mem_ack_i) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               mem_req_d   = 1'b0;
               mem_write_d = 1'b0;
               mem_be_d    = '0;
               wb_valid_d  = 1'b1;
               wb_data_d   = mem_write_q ? '0 : load_extend(op_size_q, op_uns_q, op_lane_q, mem_rdata_i);
            end else if (timeout_hit_s) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               mem_req_d   = 1'b0;
               mem_write_d = 1'b0;
               mem_be_d    = '0;
               wb_valid_d  = 1'b1;
               exc_bus_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         op_size_q   <= 2'b00;
         op_uns_q    <= 1'b0;
         op_lane_q   <= 2'b00;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         exc_mis_q   <= 1'b0;
         exc_bus_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         op_size_q   <= op_size_d;
         op_uns_q    <= op_uns_d;
         op_lane_q   <= op_lane_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         exc_mis_q   <= exc_mis_d;
         exc_bus_q   <= exc_bus_d;
      end
   end

   assign wb_valid_o     = wb_valid_q;
   assign wb_data_o      = wb_data_q;
   assign exc_misalign_o = exc_mis_q;
   assign exc_bus_o      = exc_bus_q;
   assign mem_req_o      = mem_req_q;
   assign mem_write_o    = mem_write_q;
   assign mem_addr_o     = mem_addr_q;
   assign mem_be_o       = mem_be_q;
   assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ex_valid_i;
   logic [31:0] ex_addr_i;
   logic [31:0] ex_wdata_i;
   logic        ex_read_i;
   logic        ex_write_i;
   logic [1:0]  ex_size_i;
   logic        ex_unsigned_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic        exc_misalign_o;
   logic        exc_bus_o;
   logic        mem_req_o;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;

   int tests_run    = 0;
   int tests_failed = 0;

   mem_access_unit #(.XLEN(32), .TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ex_valid_i(ex_valid_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
      .ex_read_i(ex_read_i), .ex_write_i(ex_write_i), .ex_size_i(ex_size_i),
      .ex_unsigned_i(ex_unsigned_i),
      .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
      .exc_misalign_o(exc_misalign_o), .exc_bus_o(exc_bus_o),
      .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic idle_ex();
      ex_valid_i    = 1'b0;
      ex_read_i     = 1'b0;
      ex_write_i    = 1'b0;
      ex_size_i     = 2'b00;
      ex_unsigned_i = 1'b0;
      ex_addr_i     = 32'h0;
      ex_wdata_i    = 32'h0;
   endtask

   task automatic drive_op(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
      ex_valid_i    = 1'b1;
      ex_read_i     = rd;
      ex_write_i    = wr;
      ex_size_i     = sz;
      ex_unsigned_i = uns;
      ex_addr_i     = a;
      ex_wdata_i    = d;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle_ex();
      mem_ack_i   = 1'b0;
      mem_rdata_i = 32'h0;
      step(); step();
      smp();
      tests_run++;
      if ({stall_o, wb_valid_o, exc_misalign_o, exc_bus_o, mem_req_o, mem_write_o, mem_be_o} !== 10'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b expected 0", {stall_o, wb_valid_o, exc_misalign_o, exc_bus_o, mem_req_o, mem_write_o, mem_be_o});
      end
      tests_run++;
      if ({wb_data_o, mem_addr_o, mem_wdata_o} !== 96'h0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", {wb_data_o, mem_addr_o, mem_wdata_o});
      end
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_passthru();
      step(); drive_op(1'b0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0); smp();
      tests_run++;
      if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL pass_stall: got %b expected 0", stall_o); end
      step(); idle_ex(); smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, mem_req_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
         tests_failed++; $display("FAIL pass_wb: got v=%b d=%h req=%b expected v=1 d=deadbeef req=0", wb_valid_o, wb_data_o, mem_req_o);
      end
      step(); smp();
      tests_run++;
      if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL pass_pulse: got %b expected 0", wb_valid_o); end
   endtask

   task automatic test_lb();
      step(); drive_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0); smp();
      tests_run++;
      if ({stall_o, mem_req_o} !== 2'b10) begin tests_failed++; $display("FAIL lb_accept: got stall/req=%b expected 10", {stall_o, mem_req_o}); end
      step(); idle_ex(); mem_ack_i = 1'b1; mem_rdata_i = 32'h80AA_BBCC; smp();
      tests_run++;
      if ({mem_req_o, mem_write_o, mem_be_o, mem_addr_o, stall_o, wb_valid_o} !== {1'b1, 1'b0, 4'b1000, 32'h100, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL lb_req: got req=%b wr=%b be=%b addr=%h stall=%b wbv=%b expected 1 0 1000 00000100 0 0",
                  mem_req_o, mem_write_o, mem_be_o, mem_addr_o, stall_o, wb_valid_o);
      end
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, mem_req_o, exc_misalign_o, exc_bus_o} !== {1'b1, 32'hFFFF_FF80, 3'b000}) begin
         tests_failed++; $display("FAIL lb_wb: got v=%b d=%h req/exc=%b expected v=1 d=ffffff80 000", wb_valid_o, wb_data_o, {mem_req_o, exc_misalign_o, exc_bus_o});
      end
      step(); smp();
      tests_run++;
      if (wb_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lb_pulse: got %b expected 0", wb_valid_o); end
   endtask

   task automatic test_sh();
      // read and write both set: must behave as a store
      step(); drive_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD); smp();
      step(); idle_ex(); mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; smp();
      tests_run++;
      if ({mem_req_o, mem_write_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCD_ABCD}) begin
         tests_failed++;
         $display("FAIL sh_req: got req=%b wr=%b be=%b addr=%h wd=%h expected 1 1 1100 00000200 abcdabcd",
                  mem_req_o, mem_write_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, mem_req_o} !== {1'b1, 32'h0, 1'b0}) begin
         tests_failed++; $display("FAIL sh_wb: got v=%b d=%h req=%b expected v=1 d=0 req=0", wb_valid_o, wb_data_o, mem_req_o);
      end
   endtask

   task automatic test_misalign();
      step(); drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0); smp();
      tests_run++;
      if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL mis_stall: got %b expected 0", stall_o); end
      step(); idle_ex(); smp();
      tests_run++;
      if ({wb_valid_o, exc_misalign_o, exc_bus_o, wb_data_o, mem_req_o} !== {3'b110, 32'h0, 1'b0}) begin
         tests_failed++; $display("FAIL mis_wb: got v/mis/bus=%b d=%h req=%b expected 110 d=0 req=0",
                                  {wb_valid_o, exc_misalign_o, exc_bus_o}, wb_data_o, mem_req_o);
      end
      step(); smp();
      tests_run++;
      if ({wb_valid_o, exc_misalign_o} !== 2'b00) begin tests_failed++; $display("FAIL mis_pulse: got %b expected 00", {wb_valid_o, exc_misalign_o}); end
   endtask

   task automatic test_wait_states();
      int stall_cnt = 0;
      step(); drive_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0); smp();
      if (stall_o === 1'b1) stall_cnt++;
      for (int i = 1; i <= 3; i++) begin
         step(); idle_ex(); smp();
         if (stall_o === 1'b1) stall_cnt++;
         tests_run++;
         if ({mem_req_o, mem_write_o, mem_be_o, mem_addr_o, wb_valid_o} !== {1'b1, 1'b0, 4'b0011, 32'h10, 1'b0}) begin
            tests_failed++; $display("FAIL lhu_hold%0d: got req=%b wr=%b be=%b addr=%h wbv=%b expected 1 0 0011 00000010 0",
                                     i, mem_req_o, mem_write_o, mem_be_o, mem_addr_o, wb_valid_o);
         end
      end
      step(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_F00D; smp();
      if (stall_o === 1'b1) stall_cnt++;
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o} !== {1'b1, 32'h0000_F00D}) begin
         tests_failed++; $display("FAIL lhu_wb: got v=%b d=%h expected v=1 d=0000f00d", wb_valid_o, wb_data_o);
      end
      tests_run++;
      if (stall_cnt !== 4) begin tests_failed++; $display("FAIL lhu_stall_cycles: got %0d expected 4", stall_cnt); end
   endtask

   task automatic test_timeout();
      int req_cnt = 0;
      step(); drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0); smp();
      for (int i = 1; i <= 16; i++) begin
         step(); idle_ex(); smp();
         if (mem_req_o === 1'b1) req_cnt++;
         if (i == 15) begin
            tests_run++;
            if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL to_stall15: got %b expected 1", stall_o); end
         end
         if (i == 16) begin
            tests_run++;
            if ({stall_o, wb_valid_o} !== 2'b00) begin tests_failed++; $display("FAIL to_stall16: got stall/wbv=%b expected 00", {stall_o, wb_valid_o}); end
         end
      end
      step(); mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678; smp();
      tests_run++;
      if ({mem_req_o, wb_valid_o, exc_bus_o, exc_misalign_o, wb_data_o} !== {4'b0110, 32'h0}) begin
         tests_failed++; $display("FAIL to_exc: got req/v/bus/mis=%b d=%h expected 0110 d=0",
                                  {mem_req_o, wb_valid_o, exc_bus_o, exc_misalign_o}, wb_data_o);
      end
      tests_run++;
      if (req_cnt !== 16) begin tests_failed++; $display("FAIL to_req_cycles: got %0d expected 16", req_cnt); end
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({mem_req_o, wb_valid_o, exc_bus_o} !== 3'b000) begin
         tests_failed++; $display("FAIL to_late_ack: got req/v/bus=%b expected 000", {mem_req_o, wb_valid_o, exc_bus_o});
      end
   endtask

   task automatic test_reset_mid_busy();
      step(); drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0); smp();
      step(); idle_ex(); smp();
      tests_run++;
      if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL rb_busy: got req=%b expected 1", mem_req_o); end
      rst_i = 1'b1;
      step(); rst_i = 1'b0; smp();
      tests_run++;
      if ({mem_req_o, stall_o, wb_valid_o} !== 3'b000) begin
         tests_failed++; $display("FAIL rb_abort: got req/stall/v=%b expected 000", {mem_req_o, stall_o, wb_valid_o});
      end
      step(); smp();
      tests_run++;
      if ({wb_valid_o, exc_bus_o, exc_misalign_o} !== 3'b000) begin
         tests_failed++; $display("FAIL rb_no_wb: got v/bus/mis=%b expected 000", {wb_valid_o, exc_bus_o, exc_misalign_o});
      end
      step(); drive_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0031, 32'h0); smp();
      tests_run++;
      if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL rb_new_stall: got %b expected 1", stall_o); end
      step(); idle_ex(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_FE00; smp();
      tests_run++;
      if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b0010, 32'h30}) begin
         tests_failed++; $display("FAIL rb_new_req: got req=%b be=%b addr=%h expected 1 0010 00000030", mem_req_o, mem_be_o, mem_addr_o);
      end
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o} !== {1'b1, 32'h0000_00FE}) begin
         tests_failed++; $display("FAIL rb_new_wb: got v=%b d=%h expected v=1 d=000000fe", wb_valid_o, wb_data_o);
      end
   endtask

   task automatic test_back_to_back();
      step(); drive_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0); smp();
      step(); idle_ex(); mem_ack_i = 1'b1; mem_rdata_i = 32'h1122_3344; smp();
      step(); mem_ack_i = 1'b0; drive_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0); smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, stall_o} !== {1'b1, 32'h1122_3344, 1'b1}) begin
         tests_failed++; $display("FAIL b2b_lw: got v=%b d=%h stall=%b expected v=1 d=11223344 stall=1", wb_valid_o, wb_data_o, stall_o);
      end
      step(); idle_ex(); mem_ack_i = 1'b1; mem_rdata_i = 32'h8000_1234; smp();
      tests_run++;
      if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b1100, 32'h40}) begin
         tests_failed++; $display("FAIL b2b_lh_req: got req=%b be=%b addr=%h expected 1 1100 00000040", mem_req_o, mem_be_o, mem_addr_o);
      end
      step(); mem_ack_i = 1'b0; drive_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00A5); smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, stall_o} !== {1'b1, 32'hFFFF_8000, 1'b1}) begin
         tests_failed++; $display("FAIL b2b_lh: got v=%b d=%h stall=%b expected v=1 d=ffff8000 stall=1", wb_valid_o, wb_data_o, stall_o);
      end
      step(); idle_ex(); mem_ack_i = 1'b1; smp();
      tests_run++;
      if ({mem_req_o, mem_write_o, mem_be_o, mem_wdata_o} !== {2'b11, 4'b0010, 32'hA5A5_A5A5}) begin
         tests_failed++; $display("FAIL b2b_sb_req: got req=%b wr=%b be=%b wd=%h expected 1 1 0010 a5a5a5a5",
                                  mem_req_o, mem_write_o, mem_be_o, mem_wdata_o);
      end
      step(); mem_ack_i = 1'b0; smp();
      tests_run++;
      if ({wb_valid_o, wb_data_o, mem_req_o} !== {1'b1, 32'h0, 1'b0}) begin
         tests_failed++; $display("FAIL b2b_sb_wb: got v=%b d=%h req=%b expected v=1 d=0 req=0", wb_valid_o, wb_data_o, mem_req_o);
      end
   endtask

   initial begin
      test_reset();
      test_passthru();
      test_lb();
      test_sh();
      test_misalign();
      test_wait_states();
      test_timeout();
      test_reset_mid_busy();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
